// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM path: word type, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STREAK_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

  // RAM has finished the current word, successfully or not.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err_sticky;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err_sticky
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err_sticky
  );

endinterface

// File: rtl/mem_arb_streak.sv
// Saturating count of dcache wins while icache waits; full_o flags that icache must win next.
module mem_arb_streak
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic full_o
);

  localparam logic [STREAK_W-1:0] MAX_W = STREAK_W'(MAX);

  logic [STREAK_W-1:0] cnt_q, cnt_d;
  logic                full_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_W)) begin
      cnt_d = cnt_q + STREAK_W'(1);
    end
  end

  // full is registered from the next count so the compare costs no extra cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      full_q <= (MAX_W == '0);
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == MAX_W);
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache word requests onto one RAM port.
// MEM_ARB_STARVE_GUARD_EN enables the dcache streak limit; otherwise dcache has strict priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter word_t       ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q;
  logic       err_q;
  logic       d_req, i_req;
  logic       done, ram_err;
  logic       d_done, i_done;
  logic       starve;

  assign d_req   = bus.dREN | bus.dWEN;
  assign i_req   = bus.iREN;
  assign done    = ram_done(bus.ramstate);
  assign ram_err = (bus.ramstate == ERROR);
  assign d_done  = (state_q == GRANT_D) & d_req & done;
  assign i_done  = (state_q == GRANT_I) & i_req & done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic streak_full;

  mem_arb_streak #(
    .MAX (MAX_D_STREAK)
  ) u_streak (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (d_done & i_req),
    .clr_i  (i_done | ~i_req),
    .full_o (streak_full)
  );

  assign starve = i_req & streak_full;
`else
  assign starve = 1'b0;
`endif

  // Grant FSM; a dropped request aborts the grant just like a completion
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_req && !starve) begin
            state_q <= GRANT_D;
          end else if (i_req) begin
            state_q <= GRANT_I;
          end
        end
        GRANT_D: if (!d_req || d_done) state_q <= IDLE;
        GRANT_I: if (!i_req || i_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if ((d_done || i_done) && ram_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // RAM port follows the grant and the live request lines
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      GRANT_D: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      GRANT_I: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      default: ;
    endcase
  end

  assign bus.dwait      = ~d_done;
  assign bus.iwait      = ~i_done;
  assign bus.dload      = d_done ? (ram_err ? ERR_WORD : bus.ramload) : '0;
  assign bus.iload      = i_done ? (ram_err ? ERR_WORD : bus.ramload) : '0;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a word-level memory model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned MAXS = 4;
  localparam word_t       ERRW = 32'hBAD1BAD1;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_D_STREAK (MAXS),
    .ERR_WORD     (ERRW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t ram_mem [0:511];
  word_t ref_mem [0:511];
  int    lat_left = 0;
  int    lat_max  = 3;

  bit    d_pend, d_wr, d_rd_too, i_pend;
  word_t d_addr, d_data, i_addr;
  bit    d_fin, i_fin;

  // One clock: drive cache requests, play the RAM, then sample completions.
  task automatic step(input bit err);
    @(posedge CLK);
    #1;
    bus.dREN   = d_pend & (~d_wr | d_rd_too);
    bus.dWEN   = d_pend & d_wr;
    bus.daddr  = d_addr;
    bus.dstore = d_data;
    bus.iREN   = i_pend;
    bus.iaddr  = i_addr;
    #1;
    if (bus.ramREN || bus.ramWEN) begin
      if (lat_left > 0) begin
        bus.ramstate = BUSY;
        bus.ramload  = $urandom;
        lat_left--;
      end else begin
        bus.ramstate = err ? ERROR : ACCESS;
        if (bus.ramWEN && !err) ram_mem[bus.ramaddr[8:0]] = bus.ramstore;
        bus.ramload  = err ? word_t'($urandom) : ram_mem[bus.ramaddr[8:0]];
        lat_left     = $urandom_range(lat_max, 0);
      end
    end else begin
      bus.ramstate = FREE;
      bus.ramload  = $urandom;
    end
    #1;
    d_fin = ~bus.dwait;
    i_fin = ~bus.iwait;
  endtask

  task automatic settle();
    d_pend = 0;
    i_pend = 0;
    repeat (3) step(0);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #3;
    n_checks++;
    if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err_sticky} !== 5'b00110) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp 00110", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err_sticky});
    end
    n_checks++;
    if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h exp all 0", bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_icache_read();
    i_pend = 1; i_addr = 32'h40; lat_left = 2;
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
      n_fail++; $display("FAIL iread_arb_cycle: ramREN %b iwait %b exp 0 1", bus.ramREN, bus.iwait);
    end
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 1'b1) begin
      n_fail++; $display("FAIL iread_grant: ramREN %b addr %h iwait %b exp 1 40 1", bus.ramREN, bus.ramaddr, bus.iwait);
    end
    step(0);
    n_checks++;
    if (bus.iwait !== 1'b1 || bus.iload !== 32'h0) begin
      n_fail++; $display("FAIL iread_busy: iwait %b iload %h exp 1 0", bus.iwait, bus.iload);
    end
    step(0);
    n_checks++;
    if (bus.iwait !== 1'b0 || bus.dwait !== 1'b1 || bus.iload !== ref_mem[9'h40]) begin
      n_fail++; $display("FAIL iread_done: iwait %b dwait %b iload %h exp 0 1 %h", bus.iwait, bus.dwait, bus.iload, ref_mem[9'h40]);
    end
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
      n_fail++; $display("FAIL iread_idle_after: ramREN %b iwait %b exp 0 1", bus.ramREN, bus.iwait);
    end
    settle();
  endtask

  task automatic test_priority();
    string got = "";
    i_pend = 1; i_addr = 32'h40;
    d_pend = 1; d_wr = 0; d_addr = 32'h100;
    for (int c = 0; c < 60 && (d_pend || i_pend); c++) begin
      step(0);
      n_checks++;
      if (d_fin && i_fin) begin n_fail++; $display("FAIL prio_both_waits: both 0 at cycle %0d", c); end
      if (d_fin) begin
        got = {got, "D"}; d_pend = 0;
        n_checks++;
        if (bus.dload !== ref_mem[9'h100]) begin n_fail++; $display("FAIL prio_dload: got %h exp %h", bus.dload, ref_mem[9'h100]); end
      end
      if (i_fin) begin
        got = {got, "I"}; i_pend = 0;
        n_checks++;
        if (bus.iload !== ref_mem[9'h40]) begin n_fail++; $display("FAIL prio_iload: got %h exp %h", bus.iload, ref_mem[9'h40]); end
      end
    end
    n_checks++;
    if (got != "DI") begin n_fail++; $display("FAIL prio_order: got '%s' exp 'DI'", got); end
    settle();
  endtask

  task automatic test_write();
    d_pend = 1; d_wr = 1; d_rd_too = 1; d_addr = 32'h120; d_data = 32'hDEADBEEF; lat_left = 1;
    step(0);
    step(0);
    n_checks++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h120) begin
      n_fail++; $display("FAIL write_strobes: WEN %b REN %b store %h addr %h exp 1 0 deadbeef 120", bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
    end
    step(0);
    n_checks++;
    if (bus.dwait !== 1'b0) begin n_fail++; $display("FAIL write_done: dwait %b exp 0", bus.dwait); end
    ref_mem[9'h120] = 32'hDEADBEEF;
    d_pend = 0; d_wr = 0;
    step(0);
    d_pend = 1;
    for (int c = 0; c < 20 && !d_fin; c++) step(0);
    n_checks++;
    if (!d_fin || bus.dload !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_readback: fin %b dload %h exp 1 deadbeef", d_fin, bus.dload);
    end
    settle();
  endtask

  task automatic test_starvation();
    string got = "";
    string exp = "";
    int    ncomp = 0;
    for (int k = 0; k < 10; k++)
      exp = {exp, (GUARD && ((k + 1) % (MAXS + 1) == 0)) ? "I" : "D"};
    d_pend = 1; d_wr = 0; d_addr = 32'h100 | 32'($urandom_range(255, 0));
    i_pend = 1; i_addr = 32'($urandom_range(255, 0));
    for (int c = 0; c < 400 && ncomp < 10; c++) begin
      step(0);
      n_checks++;
      if (d_fin && i_fin) begin n_fail++; $display("FAIL starve_both_waits: both 0 at cycle %0d", c); end
      if (d_fin) begin
        got = {got, "D"}; ncomp++;
        n_checks++;
        if (bus.dload !== ref_mem[d_addr[8:0]]) begin n_fail++; $display("FAIL starve_dload: got %h exp %h", bus.dload, ref_mem[d_addr[8:0]]); end
        d_addr = 32'h100 | 32'($urandom_range(255, 0));
      end
      if (i_fin) begin
        got = {got, "I"}; ncomp++;
        n_checks++;
        if (bus.iload !== ref_mem[i_addr[8:0]]) begin n_fail++; $display("FAIL starve_iload: got %h exp %h", bus.iload, ref_mem[i_addr[8:0]]); end
        i_addr = 32'($urandom_range(255, 0));
      end
    end
    n_checks++;
    if (got != exp) begin n_fail++; $display("FAIL starve_order: got '%s' exp '%s'", got, exp); end
    settle();
  endtask

  task automatic test_error();
    d_pend = 1; d_wr = 0; d_addr = 32'h104; lat_left = 0;
    step(1);
    step(1);
    n_checks++;
    if (bus.dwait !== 1'b0 || bus.dload !== ERRW || bus.err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL err_done: dwait %b dload %h sticky %b exp 0 %h 0", bus.dwait, bus.dload, bus.err_sticky, ERRW);
    end
    d_pend = 0;
    step(0);
    n_checks++;
    if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_set: got %b exp 1", bus.err_sticky); end
    repeat (3) step(0);
    n_checks++;
    if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_sticky_hold: got %b exp 1", bus.err_sticky); end
  endtask

  task automatic test_abort();
    d_pend = 1; d_wr = 0; d_addr = 32'h108; lat_left = 5;
    step(0);
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_grant: ramREN %b exp 1", bus.ramREN); end
    d_pend = 0; i_pend = 1; i_addr = 32'h48;
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin
      n_fail++; $display("FAIL abort_drop: REN %b WEN %b dwait %b exp 0 0 1", bus.ramREN, bus.ramWEN, bus.dwait);
    end
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_idle: ramREN %b exp 0", bus.ramREN); end
    lat_left = 0;
    step(0);
    n_checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h48 || bus.iwait !== 1'b0) begin
      n_fail++; $display("FAIL abort_next_grant: REN %b addr %h iwait %b exp 1 48 0", bus.ramREN, bus.ramaddr, bus.iwait);
    end
    settle();
  endtask

  task automatic test_reset_mid_grant();
    i_pend = 1; i_addr = 32'h44; lat_left = 5;
    step(0);
    step(0);
    RST = 1'b1;
    step(0);
    n_checks++;
    if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err_sticky} !== 5'b00110) begin
      n_fail++; $display("FAIL rst_mid_grant: got %b exp 00110", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.err_sticky});
    end
    RST = 1'b0;
    lat_left = 0;
    step(0);
    n_checks++;
    if (bus.iwait !== 1'b0 || bus.iload !== ref_mem[9'h44]) begin
      n_fail++; $display("FAIL rst_regrant: iwait %b iload %h exp 0 %h", bus.iwait, bus.iload, ref_mem[9'h44]);
    end
    settle();
  endtask

  task automatic test_random();
    int last = -10;
    lat_max = 4;
    for (int c = 0; c < 600; c++) begin
      if (!d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1; d_wr = 1'($urandom_range(1, 0)); d_rd_too = 1'($urandom_range(1, 0));
        d_addr = 32'h100 | 32'($urandom_range(255, 0)); d_data = $urandom;
      end
      if (!i_pend && $urandom_range(1, 0) == 1) begin
        i_pend = 1; i_addr = 32'($urandom_range(255, 0));
      end
      step(0);
      n_checks++;
      if (d_fin && i_fin) begin n_fail++; $display("FAIL rnd_both_waits: both 0 at cycle %0d", c); end
      if (d_fin || i_fin) begin
        n_checks++;
        if (c - last < 2) begin n_fail++; $display("FAIL rnd_turnaround: gap %0d exp >= 2", c - last); end
        last = c;
      end
      if (d_fin) begin
        if (d_wr) ref_mem[d_addr[8:0]] = d_data;
        else begin
          n_checks++;
          if (bus.dload !== ref_mem[d_addr[8:0]]) begin n_fail++; $display("FAIL rnd_dload: addr %h got %h exp %h", d_addr, bus.dload, ref_mem[d_addr[8:0]]); end
        end
        d_pend = 0;
      end else begin
        n_checks++;
        if (bus.dload !== 32'h0) begin n_fail++; $display("FAIL rnd_dload_idle: got %h exp 0", bus.dload); end
      end
      if (i_fin) begin
        n_checks++;
        if (bus.iload !== ref_mem[i_addr[8:0]]) begin n_fail++; $display("FAIL rnd_iload: addr %h got %h exp %h", i_addr, bus.iload, ref_mem[i_addr[8:0]]); end
        i_pend = 0;
      end else begin
        n_checks++;
        if (bus.iload !== 32'h0) begin n_fail++; $display("FAIL rnd_iload_idle: got %h exp 0", bus.iload); end
      end
    end
    n_checks++;
    if (last < 0) begin n_fail++; $display("FAIL rnd_progress: no completions seen"); end
    settle();
  endtask

  initial begin
    for (int a = 0; a < 512; a++) begin
      ram_mem[a] = $urandom;
      ref_mem[a] = ram_mem[a];
    end
    d_pend = 0; d_wr = 0; d_rd_too = 0; i_pend = 0;
    d_addr = '0; d_data = '0; i_addr = '0;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    test_reset();
    test_icache_read();
    test_priority();
    test_write();
    test_starvation();
    test_error();
    test_abort();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
